// File: rtl/ccff_pkg.sv
// Shared FSM state encoding and default geometry for the ccff chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_t;

  // One connection block: 7 muxes x 6 SRAM bits.
  localparam int CCFF_CHAIN_LEN_DEF = 42;
  localparam int CCFF_WORD_W_DEF    = 32;

endpackage

// File: rtl/ccff_readback.sv
// Purpose: collects ccff_tail bits LSB-first into words for readback.
// Latency: rb_valid pulses one cycle after the WORD_W-th (or final) sampled bit.
// Backpressure: none; each word is presented for exactly one cycle.
module ccff_readback
  import ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              clr,
  input  logic              sample,
  input  logic              last,
  input  logic              tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);

  localparam int IW = $clog2(WORD_W + 1);

  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;
  logic              full;

  // Bits land at their final position so a short last word is already zero-padded.
  always_comb begin
    acc_nxt = acc | (WORD_W'(tail) << idx);
    full    = (idx == IW'(WORD_W - 1));
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      idx      <= '0;
      acc      <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= 1'b0;
      if (clr) begin
        idx <= '0;
        acc <= '0;
      end else if (sample) begin
        if (full || last) begin
          rb_valid <= 1'b1;
          rb_data  <= acc_nxt;
          idx      <= '0;
          acc      <= '0;
        end else begin
          acc <= acc_nxt;
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Purpose: serialises cfg words LSB-first into a ccff chain (readback under CCFF_READBACK_EN).
// Latency: 1 cycle word-accept to first shift; CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) cycles per load.
// Backpressure: cfg_ready only in FETCH; chain stalls (shift_en low) while cfg_valid is low.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter int WORD_W    = CCFF_WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef CCFF_READBACK_EN
  ,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
`endif
);

  localparam int CW  = $clog2(CHAIN_LEN + 1);
  localparam int WLW = $clog2(WORD_W + 1);

  ccff_state_t       state;
  ccff_state_t       state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [WLW-1:0]    word_left;
  logic [WLW-1:0]    word_take;
  int                remain;

  // Final word is truncated so bits past CHAIN_LEN are never shifted out.
  always_comb begin
    remain    = CHAIN_LEN - int'(bit_cnt);
    word_take = (remain < WORD_W) ? WLW'(remain) : WLW'(WORD_W);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        cfg_ready = !abort;
        if (cfg_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = shreg[0];
        if (word_left == WLW'(1))
          state_nxt = (bit_cnt == CW'(CHAIN_LEN - 1)) ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_left <= '0;
      aborted   <= 1'b0;
    end else begin
      if (abort) begin
        aborted <= 1'b1;
      end else if (start && (state == IDLE || state == DONE)) begin
        bit_cnt <= '0;
        aborted <= 1'b0;
      end
      if (cfg_valid && cfg_ready) begin
        shreg     <= cfg_data;
        word_left <= word_take;
      end
      if (ccff_shift_en) begin
        shreg     <= shreg >> 1;
        bit_cnt   <= bit_cnt + CW'(1);
        word_left <= word_left - WLW'(1);
      end
    end
  end

`ifdef CCFF_READBACK_EN
  logic last_shift;
  assign last_shift = ccff_shift_en && (bit_cnt == CW'(CHAIN_LEN - 1));

  ccff_readback #(
    .WORD_W (WORD_W)
  ) u_readback (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .clr      (!busy),
    .sample   (ccff_shift_en),
    .last     (last_shift),
    .tail     (ccff_tail),
    .rb_valid (rb_valid),
    .rb_data  (rb_data)
  );
`else
  logic tail_unused;
  assign tail_unused = ccff_tail;
`endif

endmodule
